// File: rtl/game2048_pkg.sv
// Shared types for the 2048 game turn controller.
//   dir_t         : slide direction encoding shared with the slide/merge unit
//   turn_state_t  : turn controller FSM states (also visible on the debug port)
//   board_t       : 4x4 board of 12-bit tiles, indexed [row][col]
//   DEFAULT_WIN_VALUE : tile value that ends the game with a win
package game2048_pkg;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } dir_t;

   typedef enum logic [2:0] {
      INIT_SPAWN1 = 3'd0,
      INIT_SPAWN2 = 3'd1,
      IDLE        = 3'd2,
      MOVE        = 3'd3,
      SPAWN       = 3'd4,
      CHECK       = 3'd5,
      WON         = 3'd6,
      LOST        = 3'd7
   } turn_state_t;

   typedef logic [3:0][3:0][11:0] board_t;

   localparam logic [11:0] DEFAULT_WIN_VALUE = 12'h800;

endpackage

// File: rtl/board_status_check.sv
// Combinational end-of-game detection on the committed board.
//   board_i  : 4x4 board, [row][col]
//   has_win  : some tile equals WIN_VALUE
//   no_moves : no empty tile and no horizontally/vertically adjacent equal pair
module board_status_check
   import game2048_pkg::*;
#(
   parameter logic [11:0] WIN_VALUE = DEFAULT_WIN_VALUE
) (
   input  board_t board_i,
   output logic   has_win,
   output logic   no_moves
);

   logic any_zero;
   logic any_pair;

   always_comb begin
      has_win  = 1'b0;
      any_zero = 1'b0;
      any_pair = 1'b0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (board_i[r][c] == WIN_VALUE) has_win = 1'b1;
            if (board_i[r][c] == 12'd0) any_zero = 1'b1;
         end
      end
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (board_i[r][c] == board_i[r][c+1]) any_pair = 1'b1;
         end
      end
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (board_i[r][c] == board_i[r+1][c]) any_pair = 1'b1;
         end
      end
      no_moves = !any_zero && !any_pair;
   end

endmodule

// File: rtl/game_turn_controller.sv
// Sequences one game turn: accept a press, drive the slide/merge unit, spawn a
// tile when the board changed, then check for win/loss.
//   clk, rst                : clock, synchronous active-high reset
//   new_game                : restart the game (clears counters and flags)
//   btn_valid, btn_dir      : direction press, one-deep pending buffer while busy
//   board_in                : current committed board, read in CHECK
//   move_start/move_dir     : start pulse + direction to slide/merge unit
//   move_done/move_changed  : slide/merge completion, changed sampled with done
//   spawn_start/spawn_done  : start pulse / completion of random-tile placer
//   busy, game_won, game_lost, timeout_err : status flags
//   move_count, drop_count  : effective moves (wraps), dropped presses (saturates)
//   dbg_state_o             : current FSM state
//
// Handshake: a *_start output is a registered one-cycle pulse; the matching
// *_done input is a one-cycle pulse accepted only while the controller waits
// in the corresponding state (from the start pulse onward). Done pulses seen
// in any other state are ignored. A watchdog bounds every wait.
module game_turn_controller
   import game2048_pkg::*;
#(
   parameter logic [11:0] WIN_VALUE      = DEFAULT_WIN_VALUE,
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        new_game,
   input  logic        btn_valid,
   input  dir_t        btn_dir,
   input  board_t      board_in,
   output logic        move_start,
   output dir_t        move_dir,
   input  logic        move_done,
   input  logic        move_changed,
   output logic        spawn_start,
   input  logic        spawn_done,
   output logic        busy,
   output logic        game_won,
   output logic        game_lost,
   output logic        timeout_err,
   output logic [15:0] move_count,
   output logic [7:0]  drop_count,
   output turn_state_t dbg_state_o
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   turn_state_t     state_q, state_d;
   logic            issued_q, issued_d;      // spawn pulse already sent in this state
   logic [WD_W-1:0] wdog_q, wdog_d;
   logic            pend_valid_q, pend_valid_d;
   dir_t            pend_dir_q, pend_dir_d;
   logic            move_start_q, move_start_d;
   logic            spawn_start_q, spawn_start_d;
   dir_t            move_dir_q, move_dir_d;
   logic [15:0]     move_count_q, move_count_d;
   logic [7:0]      drop_count_q, drop_count_d;
   logic            timeout_q, timeout_d;
   logic            waiting;
   logic            busy_w;
   logic            has_win, no_moves;

   board_status_check #(.WIN_VALUE(WIN_VALUE)) u_status (
      .board_i  (board_in),
      .has_win  (has_win),
      .no_moves (no_moves)
   );

   assign busy_w = !(state_q inside {IDLE, WON, LOST});

   always_comb begin
      state_d       = state_q;
      issued_d      = issued_q;
      wdog_d        = wdog_q;
      pend_valid_d  = pend_valid_q;
      pend_dir_d    = pend_dir_q;
      move_start_d  = 1'b0;
      spawn_start_d = 1'b0;
      move_dir_d    = move_dir_q;
      move_count_d  = move_count_q;
      drop_count_d  = drop_count_q;
      timeout_d     = timeout_q;
      waiting       = 1'b0;

      if (busy_w && btn_valid) begin
         if (!pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_dir_d   = btn_dir;
         end else if (drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
         end
      end

      case (state_q)
         INIT_SPAWN1, INIT_SPAWN2, SPAWN: begin
            if (!issued_q) begin
               spawn_start_d = 1'b1;
               issued_d      = 1'b1;
               wdog_d        = '0;
            end else begin
               waiting = 1'b1;
               if (spawn_done) begin
                  issued_d = 1'b0;
                  if (state_q == INIT_SPAWN1)      state_d = INIT_SPAWN2;
                  else if (state_q == INIT_SPAWN2) state_d = IDLE;
                  else                             state_d = CHECK;
               end
            end
         end
         MOVE: begin
            waiting = 1'b1;
            if (move_done) begin
               if (move_changed) begin
                  move_count_d = move_count_q + 16'd1;
                  state_d      = SPAWN;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         IDLE: begin
            if (pend_valid_q) begin
               // Older press goes first; a simultaneous new press refills the slot.
               move_start_d = 1'b1;
               move_dir_d   = pend_dir_q;
               state_d      = MOVE;
               wdog_d       = '0;
               pend_valid_d = btn_valid;
               pend_dir_d   = btn_dir;
            end else if (btn_valid) begin
               move_start_d = 1'b1;
               move_dir_d   = btn_dir;
               state_d      = MOVE;
               wdog_d       = '0;
            end
         end
         CHECK: begin
            if (has_win)       state_d = WON;
            else if (no_moves) state_d = LOST;
            else               state_d = IDLE;
         end
         WON, LOST: begin
            state_d = state_q;
         end
         default: state_d = INIT_SPAWN1;
      endcase

      // Watchdog: only cycles still waiting for a done are counted.
      if (waiting && (state_d == state_q)) begin
         if (wdog_q == WD_LAST) begin
            timeout_d    = 1'b1;
            pend_valid_d = 1'b0;
            issued_d     = 1'b0;
            wdog_d       = '0;
            state_d      = IDLE;
         end else begin
            wdog_d = wdog_q + 1'b1;
         end
      end

      if (new_game) begin
         state_d       = INIT_SPAWN1;
         issued_d      = 1'b0;
         wdog_d        = '0;
         pend_valid_d  = 1'b0;
         move_count_d  = '0;
         drop_count_d  = '0;
         timeout_d     = 1'b0;
         move_start_d  = 1'b0;
         spawn_start_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= INIT_SPAWN1;
         issued_q      <= 1'b0;
         wdog_q        <= '0;
         pend_valid_q  <= 1'b0;
         pend_dir_q    <= UP;
         move_start_q  <= 1'b0;
         spawn_start_q <= 1'b0;
         move_dir_q    <= UP;
         move_count_q  <= '0;
         drop_count_q  <= '0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         issued_q      <= issued_d;
         wdog_q        <= wdog_d;
         pend_valid_q  <= pend_valid_d;
         pend_dir_q    <= pend_dir_d;
         move_start_q  <= move_start_d;
         spawn_start_q <= spawn_start_d;
         move_dir_q    <= move_dir_d;
         move_count_q  <= move_count_d;
         drop_count_q  <= drop_count_d;
         timeout_q     <= timeout_d;
      end
   end

   assign move_start  = move_start_q;
   assign spawn_start = spawn_start_q;
   assign move_dir    = move_dir_q;
   assign busy        = busy_w;
   assign game_won    = (state_q == WON);
   assign game_lost   = (state_q == LOST);
   assign timeout_err = timeout_q;
   assign move_count  = move_count_q;
   assign drop_count  = drop_count_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_game_turn_controller.sv
// Directed bench for game_turn_controller: reset, init spawns, turns, pending
// press buffer, win/loss, new_game, watchdog timeout, stray done pulses and
// reset mid-handshake.
module tb_game_turn_controller;
   import game2048_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        new_game = 1'b0;
   logic        btn_valid = 1'b0;
   dir_t        btn_dir = UP;
   board_t      board_in;
   logic        move_start;
   dir_t        move_dir;
   logic        move_done = 1'b0;
   logic        move_changed = 1'b0;
   logic        spawn_start;
   logic        spawn_done = 1'b0;
   logic        busy, game_won, game_lost, timeout_err;
   logic [15:0] move_count;
   logic [7:0]  drop_count;
   turn_state_t dbg_state;

   int total = 0;
   int bad = 0;
   int spawn_cnt = 0;
   int mv_cnt = 0;
   int viol = 0;
   logic prev_any = 1'b0;

   game_turn_controller dut (
      .clk          (clk),
      .rst          (rst),
      .new_game     (new_game),
      .btn_valid    (btn_valid),
      .btn_dir      (btn_dir),
      .board_in     (board_in),
      .move_start   (move_start),
      .move_dir     (move_dir),
      .move_done    (move_done),
      .move_changed (move_changed),
      .spawn_start  (spawn_start),
      .spawn_done   (spawn_done),
      .busy         (busy),
      .game_won     (game_won),
      .game_lost    (game_lost),
      .timeout_err  (timeout_err),
      .move_count   (move_count),
      .drop_count   (drop_count),
      .dbg_state_o  (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // pulse monitor: counts start pulses, flags overlapping or back-to-back ones
   always @(negedge clk) begin
      if (move_start && spawn_start) viol++;
      if ((move_start || spawn_start) && prev_any) viol++;
      prev_any = move_start || spawn_start;
      if (spawn_start) spawn_cnt++;
      if (move_start) mv_cnt++;
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic board_sparse();
      board_in = '0;
      board_in[0][0] = 12'h002;
      board_in[1][2] = 12'h004;
   endtask

   // all tiles distinct and non-zero: no merges possible
   task automatic board_stuck();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            board_in[r][c] = 12'(r * 4 + c + 1);
   endtask

   task automatic press(input dir_t d);
      btn_valid = 1'b1;
      btn_dir   = d;
      tick();
      btn_valid = 1'b0;
   endtask

   // wait for a spawn pulse, answer with spawn_done 3 cycles later
   task automatic do_spawn();
      bit ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (spawn_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL spawn_wait: spawn_start=%0b after 10 cycles, required 1", spawn_start);
      end
      repeat (3) tick();
      spawn_done = 1'b1;
      tick();
      spawn_done = 1'b0;
   endtask

   task automatic finish_move(input bit changed);
      repeat (2) tick();
      move_done    = 1'b1;
      move_changed = changed;
      tick();
      move_done    = 1'b0;
      move_changed = 1'b0;
   endtask

   // one full turn ending in the CHECK cycle (when changed) or IDLE
   task automatic do_turn(input dir_t d, input bit changed);
      press(d);
      total++;
      if (move_start !== 1'b1) begin
         bad++;
         $display("FAIL turn_move_start: got %0b, required 1", move_start);
      end
      finish_move(changed);
      if (changed) do_spawn();
   endtask

   task automatic init_spawns();
      do_spawn();
      do_spawn();
   endtask

   // tests
   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++;
      if (dbg_state !== INIT_SPAWN1 || busy !== 1'b1 || move_start !== 1'b0 ||
          spawn_start !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: state=%0d busy=%0b ms=%0b ss=%0b, required 0 1 0 0",
                  dbg_state, busy, move_start, spawn_start);
      end
      total++;
      if (move_count !== 16'd0 || drop_count !== 8'd0 || game_won !== 1'b0 ||
          game_lost !== 1'b0 || timeout_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_counters: mc=%0d dc=%0d won=%0b lost=%0b to=%0b, required all 0",
                  move_count, drop_count, game_won, game_lost, timeout_err);
      end
      rst = 1'b0;
   endtask

   task automatic test_init_spawn();
      int s0 = spawn_cnt;
      init_spawns();
      repeat (5) tick();
      total++;
      if (spawn_cnt - s0 !== 2) begin
         bad++;
         $display("FAIL init_spawn_count: got %0d pulses, required 2", spawn_cnt - s0);
      end
      total++;
      if (dbg_state !== IDLE || busy !== 1'b0) begin
         bad++;
         $display("FAIL init_idle: state=%0d busy=%0b, required %0d 0", dbg_state, busy, IDLE);
      end
   endtask

   task automatic test_move_left();
      int s0 = spawn_cnt;
      press(LEFT);
      total++;
      if (move_start !== 1'b1 || move_dir !== LEFT || busy !== 1'b1) begin
         bad++;
         $display("FAIL left_start: ms=%0b dir=%0d busy=%0b, required 1 2 1",
                  move_start, move_dir, busy);
      end
      finish_move(1'b1);
      total++;
      if (move_count !== 16'd1 || dbg_state !== SPAWN) begin
         bad++;
         $display("FAIL left_count: mc=%0d state=%0d, required 1 %0d", move_count, dbg_state, SPAWN);
      end
      do_spawn();
      tick();
      total++;
      if (spawn_cnt - s0 !== 1 || dbg_state !== IDLE) begin
         bad++;
         $display("FAIL left_spawn: pulses=%0d state=%0d, required 1 %0d",
                  spawn_cnt - s0, dbg_state, IDLE);
      end
   endtask

   task automatic test_pending();
      press(UP);
      tick();
      press(RIGHT);
      tick();
      press(DOWN);
      press(DOWN);
      total++;
      if (drop_count !== 8'd2) begin
         bad++;
         $display("FAIL pend_drop: dc=%0d, required 2", drop_count);
      end
      finish_move(1'b0);
      tick();
      total++;
      if (move_start !== 1'b1 || move_dir !== RIGHT) begin
         bad++;
         $display("FAIL pend_replay: ms=%0b dir=%0d, required 1 3", move_start, move_dir);
      end
      finish_move(1'b0);
      tick();
      total++;
      if (dbg_state !== IDLE || move_count !== 16'd1 || move_start !== 1'b0) begin
         bad++;
         $display("FAIL pend_idle: state=%0d mc=%0d ms=%0b, required %0d 1 0",
                  dbg_state, move_count, move_start, IDLE);
      end
   endtask

   task automatic test_back_to_back();
      press(UP);
      press(LEFT);
      finish_move(1'b0);
      press(DOWN);
      total++;
      if (move_start !== 1'b1 || move_dir !== LEFT) begin
         bad++;
         $display("FAIL b2b_first: ms=%0b dir=%0d, required 1 2", move_start, move_dir);
      end
      finish_move(1'b0);
      tick();
      total++;
      if (move_start !== 1'b1 || move_dir !== DOWN || drop_count !== 8'd2) begin
         bad++;
         $display("FAIL b2b_second: ms=%0b dir=%0d dc=%0d, required 1 1 2",
                  move_start, move_dir, drop_count);
      end
      finish_move(1'b0);
   endtask

   task automatic test_win();
      int m0;
      board_sparse();
      board_in[3][3] = 12'h800;
      do_turn(RIGHT, 1'b1);
      tick();
      total++;
      if (game_won !== 1'b1 || game_lost !== 1'b0 || busy !== 1'b0 || move_count !== 16'd2) begin
         bad++;
         $display("FAIL win_flag: won=%0b lost=%0b busy=%0b mc=%0d, required 1 0 0 2",
                  game_won, game_lost, busy, move_count);
      end
      m0 = mv_cnt;
      press(UP);
      repeat (3) tick();
      total++;
      if (mv_cnt !== m0 || drop_count !== 8'd2 || game_won !== 1'b1) begin
         bad++;
         $display("FAIL win_ignore: pulses=%0d dc=%0d won=%0b, required 0 2 1",
                  mv_cnt - m0, drop_count, game_won);
      end
   endtask

   task automatic test_lose();
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      total++;
      if (dbg_state !== INIT_SPAWN1 || game_won !== 1'b0 || move_count !== 16'd0 ||
          drop_count !== 8'd0) begin
         bad++;
         $display("FAIL newgame_from_won: state=%0d won=%0b mc=%0d dc=%0d, required 0 0 0 0",
                  dbg_state, game_won, move_count, drop_count);
      end
      init_spawns();
      // full board with one vertical equal pair: still playable
      board_stuck();
      board_in[2][1] = board_in[1][1];
      do_turn(UP, 1'b1);
      tick();
      total++;
      if (dbg_state !== IDLE || game_lost !== 1'b0) begin
         bad++;
         $display("FAIL lose_pair_ok: state=%0d lost=%0b, required %0d 0", dbg_state, game_lost, IDLE);
      end
      board_stuck();
      do_turn(DOWN, 1'b1);
      tick();
      total++;
      if (game_lost !== 1'b1 || game_won !== 1'b0 || move_count !== 16'd2) begin
         bad++;
         $display("FAIL lose_flag: lost=%0b won=%0b mc=%0d, required 1 0 2",
                  game_lost, game_won, move_count);
      end
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      total++;
      if (game_lost !== 1'b0 || dbg_state !== INIT_SPAWN1 || move_count !== 16'd0) begin
         bad++;
         $display("FAIL lose_newgame: lost=%0b state=%0d mc=%0d, required 0 0 0",
                  game_lost, dbg_state, move_count);
      end
      // stuck board that also holds the win tile: win has priority
      init_spawns();
      board_stuck();
      board_in[0][0] = 12'h800;
      do_turn(LEFT, 1'b1);
      tick();
      total++;
      if (game_won !== 1'b1 || game_lost !== 1'b0) begin
         bad++;
         $display("FAIL win_priority: won=%0b lost=%0b, required 1 0", game_won, game_lost);
      end
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      init_spawns();
      board_sparse();
   endtask

   task automatic test_timeout();
      press(UP);
      press(LEFT);
      repeat (1022) tick();
      total++;
      if (dbg_state !== MOVE || timeout_err !== 1'b0) begin
         bad++;
         $display("FAIL timeout_early: state=%0d to=%0b, required %0d 0", dbg_state, timeout_err, MOVE);
      end
      tick();
      total++;
      if (dbg_state !== IDLE || timeout_err !== 1'b1) begin
         bad++;
         $display("FAIL timeout_flag: state=%0d to=%0b, required %0d 1", dbg_state, timeout_err, IDLE);
      end
      tick();
      total++;
      if (move_start !== 1'b0 || dbg_state !== IDLE) begin
         bad++;
         $display("FAIL timeout_pend_clr: ms=%0b state=%0d, required 0 %0d", move_start, dbg_state, IDLE);
      end
   endtask

   task automatic test_spurious_done();
      int m0 = mv_cnt;
      int s0 = spawn_cnt;
      move_done    = 1'b1;
      move_changed = 1'b1;
      spawn_done   = 1'b1;
      tick();
      move_done    = 1'b0;
      move_changed = 1'b0;
      spawn_done   = 1'b0;
      repeat (3) tick();
      total++;
      if (dbg_state !== IDLE || move_count !== 16'd0 || mv_cnt !== m0 || spawn_cnt !== s0 ||
          timeout_err !== 1'b1) begin
         bad++;
         $display("FAIL stray_done: state=%0d mc=%0d mp=%0d sp=%0d to=%0b, required %0d 0 0 0 1",
                  dbg_state, move_count, mv_cnt - m0, spawn_cnt - s0, timeout_err, IDLE);
      end
   endtask

   task automatic test_rst_mid();
      int m0;
      press(RIGHT);
      tick();
      rst = 1'b1;
      new_game = 1'b1;
      tick();
      rst = 1'b0;
      new_game = 1'b0;
      m0 = mv_cnt;
      total++;
      if (dbg_state !== INIT_SPAWN1 || move_start !== 1'b0 || spawn_start !== 1'b0 ||
          timeout_err !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid: state=%0d ms=%0b ss=%0b to=%0b, required 0 0 0 0",
                  dbg_state, move_start, spawn_start, timeout_err);
      end
      move_done    = 1'b1;
      move_changed = 1'b1;
      tick();
      move_done    = 1'b0;
      move_changed = 1'b0;
      repeat (4) tick();
      total++;
      if (mv_cnt !== m0 || move_count !== 16'd0) begin
         bad++;
         $display("FAIL rst_abandon: move pulses=%0d mc=%0d, required 0 0", mv_cnt - m0, move_count);
      end
   endtask

   initial begin
      board_sparse();
      test_reset();
      test_init_spawn();
      test_move_left();
      test_pending();
      test_back_to_back();
      test_win();
      test_lose();
      test_timeout();
      test_spurious_done();
      test_rst_mid();
      total++;
      if (viol !== 0) begin
         bad++;
         $display("FAIL pulse_spacing: %0d overlapping/consecutive start pulses, required 0", viol);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/game_turn_controller.md
GAME_TURN_CONTROLLER -- requirements
Module: game_turn_controller

Interface
REQ-001 SHALL have parameter WIN_VALUE, default 12'h800, tile value that wins the game.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum cycles to wait for any done handshake.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port new_game, input, 1, request to restart the game.
REQ-006 SHALL have port btn_valid, input, 1, a direction press is present this cycle.
REQ-007 SHALL have port btn_dir, input, 2, the pressed direction (dir_t).
REQ-008 SHALL have port board_in, input, [3:0][3:0] x 12, the current committed board.
REQ-009 SHALL have port move_start, output, 1, one-cycle start pulse to the slide/merge unit.
REQ-010 SHALL have port move_dir, output, 2, direction for the slide/merge unit.
REQ-011 SHALL have port move_done, input, 1, the slide/merge unit has finished.
REQ-012 SHALL have port move_changed, input, 1, the board changed; sampled with move_done.
REQ-013 SHALL have port spawn_start, output, 1, one-cycle start pulse to the random-tile placer.
REQ-014 SHALL have port spawn_done, input, 1, the random-tile placer has finished.
REQ-015 SHALL have ports busy, game_won, game_lost and timeout_err, output, 1 each, status flags.
REQ-016 SHALL have port move_count, output, 16, count of accepted, effective moves.
REQ-017 SHALL have port drop_count, output, 8, count of discarded presses; saturates at 255.

Function
REQ-018 SHALL implement the states INIT_SPAWN1, INIT_SPAWN2, IDLE, MOVE, SPAWN, CHECK, WON, LOST.
REQ-019 INIT_SPAWN1 SHALL pulse spawn_start, then wait for spawn_done, then go to INIT_SPAWN2; INIT_SPAWN2 SHALL do the same, then go to IDLE.
REQ-020 In IDLE, with btn_valid or a pending press, SHALL pulse move_start with move_dir set from the pending press first, otherwise from btn_dir, then enter MOVE.
REQ-021 In MOVE, on move_done: if move_changed=1, increment move_count (wrapping at 16 bits) and go to SPAWN; otherwise go to IDLE with no spawn.
REQ-022 SHALL pulse spawn_start on the cycle after entering SPAWN, then on spawn_done go to CHECK.
REQ-023 CHECK SHALL last exactly one cycle and go to WON if any board_in tile equals WIN_VALUE, else to LOST if no tile is 0 and no horizontally or vertically adjacent pair is equal, else to IDLE; a win takes priority over a loss.
REQ-024 WON and LOST SHALL be sticky: game_won or game_lost stays 1 until new_game or rst.
REQ-025 busy SHALL be 1 in every state except IDLE, WON and LOST.
REQ-026 A btn_valid arriving while busy SHALL be latched into a one-deep pending register if that register is empty; otherwise drop_count SHALL increment.
REQ-027 btn_valid in WON or LOST SHALL be ignored and SHALL NOT be counted.
REQ-028 If btn_valid coincides with the press being consumed from the pending register in IDLE, the new press SHALL become the new pending entry.
REQ-029 A watchdog SHALL count cycles spent waiting for move_done or spawn_done; when it reaches TIMEOUT_CYCLES, set timeout_err (sticky), clear pending, and go to IDLE.
REQ-030 new_game in any state SHALL clear move_count, drop_count, pending, game_won, game_lost and timeout_err, and go to INIT_SPAWN1 on the next cycle.
REQ-031 move_start and spawn_start SHALL never be asserted on consecutive cycles or together.
REQ-032 A done input arriving outside its matching wait state SHALL be ignored.

Reset
REQ-033 On rst=1 at a clk edge, state SHALL become INIT_SPAWN1, and all counters, flags, pending, move_start and spawn_start SHALL become 0.
REQ-034 rst SHALL take priority over new_game; rst asserted mid-handshake SHALL abandon the operation without issuing any further pulse.

Structure
REQ-035 The shared package game2048_pkg SHALL hold dir_t (UP=0, DOWN=1, LEFT=2, RIGHT=3), turn_state_t and the default WIN_VALUE.
REQ-036 Win and loss detection SHALL be a combinational sub-module named board_status_check with outputs has_win and no_moves.

Verification
REQ-037 Reset, then spawn_done returned 3 cycles after each pulse -> exactly two spawn_start pulses, then IDLE with busy=0.
REQ-038 Press LEFT, move_done=1 with move_changed=1 -> move_dir=2, spawn_start pulse, move_count=1.
REQ-039 Press during MOVE, then two more presses -> first press executes afterwards from pending, drop_count=2.
REQ-040 Board containing 12'h800 at CHECK -> game_won=1; a later press produces no move_start.
REQ-041 Full board with no equal neighbours -> game_lost=1; new_game -> flags clear and INIT_SPAWN1.
REQ-042 move_done withheld for 1024 cycles -> timeout_err=1, state IDLE.
